// File: rtl/mips_pkg.sv
// Shared MIPS constants for the ALU dispatcher: ALU control codes, opcode/funct values,
// dispatcher FSM encoding and a sign-extension helper.
package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: opcode/funct to ALU control, immediate select,
// branch-compare flag and illegal-instruction flag.
module alu_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] control,
   output logic       use_imm,
   output logic       is_beq,
   output logic       illegal
);

   // Instruction decode table
   always_comb begin
      control = ALU_ADD;
      use_imm = 1'b0;
      is_beq  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  control = ALU_ADD;
               FN_SUB:  control = ALU_SUB;
               FN_AND:  control = ALU_AND;
               FN_OR:   control = ALU_OR;
               FN_SLT:  control = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: begin
            control = ALU_ADD;
            use_imm = 1'b1;
         end
         OP_BEQ: begin
            control = ALU_SUB;
            is_beq  = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_dispatch.sv
// Request/response front end for an external ALU: decodes a MIPS request, holds
// operands stable for EXEC_CYCLES cycles, then captures and presents the result.
module alu_dispatch
   import mips_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [5:0]  req_funct,
   input  logic [31:0] req_rs_val,
   input  logic [31:0] req_rt_val,
   input  logic [15:0] req_imm,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_branch_taken,
   output logic        rsp_illegal
);

   localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  cnt_r;
   logic        beq_r;
   logic [2:0]  dec_control_s;
   logic        dec_use_imm_s;
   logic        dec_is_beq_s;
   logic        dec_illegal_s;
   logic        accept_s;
   logic        last_s;
   logic        handshake_s;

   alu_decode u_decode (
      .opcode  (req_opcode),
      .funct   (req_funct),
      .control (dec_control_s),
      .use_imm (dec_use_imm_s),
      .is_beq  (dec_is_beq_s),
      .illegal (dec_illegal_s)
   );

   assign accept_s    = req_valid && req_ready && (state_r == ST_IDLE);
   assign last_s      = (cnt_r == LAST_CNT);
   assign handshake_s = rsp_valid && rsp_ready;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = dec_illegal_s ? ST_RESP : ST_EXEC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (last_s) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_RESP: begin
            if (handshake_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, hold counter and handshake flags; rsp_valid lags entry to RESP by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state_r   <= state_s;
         req_ready <= (state_s == ST_IDLE);
         rsp_valid <= (state_r == ST_RESP) && !handshake_s;
         if ((state_r == ST_EXEC) && !last_s) begin
            cnt_r <= cnt_r + 4'd1;
         end else begin
            cnt_r <= 4'd0;
         end
      end
   end

   // Operand registers and response capture; illegal requests leave the ALU inputs untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a            <= 32'd0;
         alu_b            <= 32'd0;
         alu_control      <= 3'b000;
         beq_r            <= 1'b0;
         rsp_result       <= 32'd0;
         rsp_zero         <= 1'b0;
         rsp_branch_taken <= 1'b0;
         rsp_illegal      <= 1'b0;
      end else if (accept_s) begin
         beq_r <= dec_is_beq_s;
         if (dec_illegal_s) begin
            rsp_result       <= 32'd0;
            rsp_zero         <= 1'b0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b1;
         end else begin
            alu_a       <= req_rs_val;
            alu_b       <= dec_use_imm_s ? sign_ext16(req_imm) : req_rt_val;
            alu_control <= dec_control_s;
         end
      end else if ((state_r == ST_EXEC) && last_s) begin
         rsp_result       <= alu_result;
         rsp_zero         <= alu_zero;
         rsp_branch_taken <= beq_r & alu_zero;
         rsp_illegal      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed bench for alu_dispatch against a behavioural MIPS ALU model;
// a second instance with EXEC_CYCLES=4 is used for the mid-operation reset scenario.
module tb_alu_dispatch;

   localparam int EC1 = 1;
   localparam int EC4 = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_valid4;
   logic [5:0]  req_opcode, req_funct;
   logic [31:0] req_rs_val, req_rt_val;
   logic [15:0] req_imm;
   logic        rsp_ready;

   logic        req_ready, rsp_valid, rsp_zero, rsp_branch_taken, rsp_illegal, alu_zero;
   logic [31:0] alu_a, alu_b, alu_result, rsp_result;
   logic [2:0]  alu_control;

   logic        req_ready4, rsp_valid4, rsp_zero4, rsp_branch_taken4, rsp_illegal4, alu_zero4;
   logic [31:0] alu_a4, alu_b4, alu_result4, rsp_result4;
   logic [2:0]  alu_control4;

   int checks   = 0;
   int failures = 0;

   // Stand-in ALU driven by the dispatcher operands
   function automatic logic [31:0] alu_stub(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result  = alu_stub(alu_control, alu_a, alu_b);
   assign alu_zero    = (alu_result == 32'd0);
   assign alu_result4 = alu_stub(alu_control4, alu_a4, alu_b4);
   assign alu_zero4   = (alu_result4 == 32'd0);

   alu_dispatch #(.EXEC_CYCLES(EC1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct), .req_rs_val(req_rs_val),
      .req_rt_val(req_rt_val), .req_imm(req_imm), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_branch_taken(rsp_branch_taken), .rsp_illegal(rsp_illegal)
   );

   alu_dispatch #(.EXEC_CYCLES(EC4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_opcode(req_opcode), .req_funct(req_funct), .req_rs_val(req_rs_val),
      .req_rt_val(req_rt_val), .req_imm(req_imm), .alu_a(alu_a4), .alu_b(alu_b4),
      .alu_control(alu_control4), .alu_result(alu_result4), .alu_zero(alu_zero4),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_result(rsp_result4),
      .rsp_zero(rsp_zero4), .rsp_branch_taken(rsp_branch_taken4), .rsp_illegal(rsp_illegal4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Architectural meaning of each instruction, straight from the MIPS definitions
   task automatic ref_model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [15:0] imm,
                            output logic legal, output logic [31:0] res, output logic [31:0] b,
                            output logic beq);
      legal = 1'b1;
      beq   = 1'b0;
      b     = rt;
      res   = 32'd0;
      if (op == 6'd0) begin
         if (fn == 6'd32)      res = rs + rt;
         else if (fn == 6'd34) res = rs - rt;
         else if (fn == 6'd36) res = rs & rt;
         else if (fn == 6'd37) res = rs | rt;
         else if (fn == 6'd42) res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
         else                  legal = 1'b0;
      end else if (op == 6'd35 || op == 6'd43 || op == 6'd8) begin
         b   = {{16{imm[15]}}, imm};
         res = rs + b;
      end else if (op == 6'd4) begin
         beq = 1'b1;
         res = rs - rt;
      end else begin
         legal = 1'b0;
      end
      if (!legal) res = 32'd0;
   endtask

   task automatic do_txn(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input int hold);
      logic        legal, beq, exp_zero;
      logic [31:0] res, eb, prev_a;
      logic [2:0]  prev_ctrl;
      int          n, lat, exp_lat;
      ref_model(op, fn, rs, rt, imm, legal, res, eb, beq);
      exp_zero = legal && (res == 32'd0);
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("ready_wait", 32'(n < 50), 32'd1);
      prev_ctrl  = alu_control;
      prev_a     = alu_a;
      req_valid  = 1'b1;
      req_opcode = op; req_funct = fn; req_rs_val = rs; req_rt_val = rt; req_imm = imm;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_rs_val = $urandom; req_rt_val = $urandom; req_imm = 16'($urandom);
      check("ready_drop", 32'(req_ready), 32'd0);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      exp_lat = legal ? (1 + EC1) : 1;
      check("latency", 32'(lat), 32'(exp_lat));
      check("result", rsp_result, res);
      check("zero", 32'(rsp_zero), 32'(exp_zero));
      check("branch", 32'(rsp_branch_taken), 32'(beq && exp_zero));
      check("illegal", 32'(rsp_illegal), 32'(!legal));
      if (legal) begin
         check("alu_a", alu_a, rs);
         check("alu_b", alu_b, eb);
      end else begin
         check("ctrl_keep", 32'(alu_control), 32'(prev_ctrl));
         check("a_keep", alu_a, prev_a);
      end
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_opcode = 6'd0; req_funct = 6'd32;
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_result", rsp_result, res);
         check("hold_illegal", 32'(rsp_illegal), 32'(!legal));
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rel_valid", 32'(rsp_valid), 32'd0);
      check("rel_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op, fn;
      logic [31:0] rs, rt;
      logic        seen;
      rst_n = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0;
      req_opcode = 6'd0; req_funct = 6'd0; req_rs_val = 32'd0; req_rt_val = 32'd0; req_imm = 16'd0;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_ctrl", 32'(alu_control), 32'd0);
      check("rst_a", alu_a, 32'd0);
      check("rst_illegal", 32'(rsp_illegal), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_ready", 32'(req_ready), 32'd1);

      do_txn(6'd0, 6'd32, 32'd5, 32'd7, 16'd0, 0);
      check("add_res", rsp_result === 32'd12 ? 32'd1 : 32'd0, 32'd1);
      do_txn(6'd4, 6'd0, 32'h1234, 32'h1234, 16'd0, 0);
      check("beq_ctrl", 32'(alu_control), 32'(3'b110));
      do_txn(6'd4, 6'd0, 32'd1, 32'd2, 16'd0, 0);
      do_txn(6'd35, 6'd0, 32'h100, 32'd0, 16'hFFFC, 0);
      check("lw_b", alu_b, 32'hFFFF_FFFC);
      do_txn(6'd63, 6'd0, 32'd9, 32'd9, 16'd0, 0);
      do_txn(6'd0, 6'd34, 32'd100, 32'd40, 16'd0, 5);

      for (int k = 0; k < 40; k++) begin
         rs = $urandom; rt = $urandom; fn = 6'($urandom);
         case ($urandom_range(0, 6))
            0: begin op = 6'd0; fn = ($urandom_range(0, 1) == 0) ? 6'd32 : 6'd42; end
            1: op = 6'd35;
            2: op = 6'd43;
            3: op = 6'd8;
            4: begin op = 6'd4; if ($urandom_range(0, 1) == 0) rt = rs; end
            5: op = 6'($urandom);
            default: begin op = 6'd0; if ($urandom_range(0, 1) == 0) fn = 6'd36 + 6'($urandom_range(0, 1)); end
         endcase
         do_txn(op, fn, rs, rt, 16'($urandom), $urandom_range(0, 3));
      end

      // Reset the EXEC_CYCLES=4 instance while it is executing
      check("d4_ready", 32'(req_ready4), 32'd1);
      req_valid4 = 1'b1; req_opcode = 6'd0; req_funct = 6'd32; req_rs_val = 32'd5; req_rt_val = 32'd7;
      @(posedge clk); #1;
      req_valid4 = 1'b0;
      @(posedge clk); #1;
      check("d4_exec_a", alu_a4, 32'd5);
      check("d4_exec_valid", 32'(rsp_valid4), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("d4_rst_valid", 32'(rsp_valid4), 32'd0);
      check("d4_rst_ready", 32'(req_ready4), 32'd0);
      check("d4_rst_a", alu_a4, 32'd0);
      check("d4_rst_b", alu_b4, 32'd0);
      check("d4_rst_ctrl", 32'(alu_control4), 32'd0);
      check("d4_rst_res", rsp_result4, 32'd0);
      check("d4_rst_flags", {29'd0, rsp_zero4, rsp_branch_taken4, rsp_illegal4}, 32'd0);
      @(posedge clk); #1;
      check("d4_rst_hold_ready", 32'(req_ready4), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (rsp_valid4) seen = 1'b1;
         if (i == 0) check("d4_first_ready", 32'(req_ready4), 32'd1);
      end
      check("d4_no_rsp", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, cycles the dispatcher holds ALU inputs stable before sampling the ALU outputs (legal 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  dispatcher accepts a request this cycle.
REQ-006 req_opcode  input  6  MIPS opcode.
REQ-007 req_funct  input  6  MIPS funct (R-type only).
REQ-008 req_rs_val  input  32  rs operand value.
REQ-009 req_rt_val  input  32  rt operand value.
REQ-010 req_imm  input  16  I-type immediate.
REQ-011 alu_a  output  32  ALU operand a.
REQ-012 alu_b  output  32  ALU operand b.
REQ-013 alu_control  output  3  ALU operation code.
REQ-014 alu_result  input  32  ALU result.
REQ-015 alu_zero  input  1  ALU zero flag.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_result  output  32  captured ALU result.
REQ-019 rsp_zero  output  1  captured zero flag.
REQ-020 rsp_branch_taken  output  1  beq request with zero set.
REQ-021 rsp_illegal  output  1  request not decodable.

Function
REQ-022 Decode SHALL be: opcode 000000 with funct 100000/100010/100100/100101/101010 -> control 010/110/000/001/111, a=rs, b=rt; opcode 100011 (lw), 101011 (sw), 001000 (addi) -> 010, a=rs, b=sign-extended imm; opcode 000100 (beq) -> 110, a=rs, b=rt; anything else illegal.
REQ-023 FSM states SHALL be IDLE, EXEC, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-024 IDLE with req_valid: register a, b, control, beq flag, illegal flag; go to EXEC if legal, RESP if illegal.
REQ-025 EXEC: alu_a/alu_b/alu_control driven from registers, stable; counter counts EXEC_CYCLES cycles; on the last, capture alu_result, alu_zero into rsp_result, rsp_zero, set rsp_branch_taken = beq flag AND alu_zero; go to RESP.
REQ-026 Legal latency: request accepted at edge N -> rsp_valid high after edge N+1+EXEC_CYCLES; illegal: rsp_valid high after edge N+1.
REQ-027 Illegal response: rsp_result=0, rsp_zero=0, rsp_branch_taken=0, rsp_illegal=1; ALU outputs not sampled.
REQ-028 RESP: all rsp_* outputs held stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE; req_ready high the following cycle (no same-cycle accept).
REQ-029 alu_a/alu_b/alu_control SHALL hold their last value outside EXEC; request inputs ignored outside IDLE.
REQ-030 rsp_illegal SHALL be 0 on every legal response.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, counter 0, req_ready 0 while asserted, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_branch_taken 0, rsp_illegal 0, alu_a 0, alu_b 0, alu_control 000.
REQ-032 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response; first req_ready high is the first cycle after rst_n deasserts.

Structure
REQ-033 ALU control codes, opcode and funct constants, FSM state encoding SHALL live in shared package mips_pkg.
REQ-034 Decode SHALL be a combinational sub-module alu_decode (opcode, funct -> control, use_imm, is_beq, illegal).

Verification
REQ-035 add: opcode 000000 funct 100000, rs=5, rt=7, ALU model -> rsp_result=12, rsp_zero=0, rsp_valid after N+2 (EXEC_CYCLES=1).
REQ-036 beq: opcode 000100, rs=rt=0x1234 -> control 110, rsp_zero=1, rsp_branch_taken=1; rs=1, rt=2 -> branch_taken=0.
REQ-037 lw: opcode 100011, rs=0x100, imm=0xFFFC -> alu_b=0xFFFFFFFC, rsp_result=0xFC.
REQ-038 illegal: opcode 111111 -> rsp_illegal=1, rsp_result=0, rsp_valid after N+1; alu_control unchanged.
REQ-039 backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready 0 throughout; new req_valid ignored until IDLE.
REQ-040 rst_n asserted during EXEC with EXEC_CYCLES=4 -> rsp_valid never rises, all outputs at reset values.
